sipo_capture_controller: RTL and testbench
==========================================

Name: sipo_capture_controller

Overview:
Parametrised successor to the single-channel SIPO control FSM. Deserialises NUM_CH parallel hydrophone bit streams (MSB first) into DATA_WIDTH words per channel for a fixed-length capture frame. A start request from the button handler triggers each frame. A per-word ready/ack handshake feeds downstream logging, with overrun detection. Sits between the ADC serial front end and the sample buffer / logging logic.

Parameters:
DATA_WIDTH, 16, bits per sample word per channel
NUM_CH, 4, number of serial channels (hydrophones)
FRAME_LEN, 256, words per channel per capture frame (>=1)
SETTLE_CYCLES, 4, idle cycles between start and logging (0 allowed)
CNT_W, clog2(FRAME_LEN+1), derived width of sample_count

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
control_signal  in  1  start request from button handler (level; rising edge starts a frame)
abort  in  1  synchronous abort of the current frame
bit_valid  in  1  strobe: serial_in holds one valid bit on every channel
serial_in  in  NUM_CH  one serial bit per channel, MSB first
data_ack  in  1  consumer accepts the presented word
data_logging  out  1  high while in LOG state
data_ready  out  1  parallel_out holds an unacknowledged word
parallel_out  out  NUM_CH*DATA_WIDTH  channel c at [c*DATA_WIDTH +: DATA_WIDTH]
sample_count  out  CNT_W  words completed in the current frame
overrun  out  1  sticky: a word completed while the previous word was unacknowledged

Behaviour:
- Reset: state IDLE; all outputs 0; shift registers, bit index, settle counter and edge-detect register cleared. Reset mid-frame discards everything.
- Start edge: control_signal high and its registered previous value low. Edges are ignored outside IDLE.
- IDLE: on a start edge go to SETTLE (or to LOG if SETTLE_CYCLES=0). Also clear sample_count, overrun and bit index on that edge.
- SETTLE: count SETTLE_CYCLES cycles; bit_valid ignored; data_logging=0; then go to LOG.
- LOG: data_logging=1. On bit_valid, each channel shifts: sh[c] <= {sh[c][W-2:0], serial_in[c]}. The bit index increments and wraps at DATA_WIDTH-1.
- Word completion: bit_valid while bit index = DATA_WIDTH-1. Latency 1 cycle: on the next cycle parallel_out is updated, data_ready=1 and sample_count increments.
- Handshake: data_ack while data_ready=1 clears data_ready next cycle. data_ack while data_ready=0 is ignored.
- Overrun: a word completes while data_ready=1 and no data_ack in that cycle. Then:
  - overrun sets (sticky until the next start or reset);
  - parallel_out keeps the old word and the new word is dropped;
  - sample_count still increments (frames are time-based).
- Ack coincident with completion: the new word loads, data_ready stays 1, no overrun.
- Frame end: when sample_count reaches FRAME_LEN, go to DRAIN. bit_valid is ignored from then on; sample_count saturates.
- DRAIN: data_logging=0; wait until data_ready=0 (last ack), then DONE.
- DONE: lasts one cycle, then IDLE. parallel_out and sample_count are held until the next start.
- abort: from SETTLE, LOG or DRAIN go to IDLE next cycle. data_ready clears and partial shift bits are discarded. parallel_out, sample_count and overrun are held. abort and reset both outrank every other event.
- FRAME_LEN=1: DRAIN is entered after the first word.
- State encoding: IDLE=0, SETTLE=1, LOG=2, DRAIN=3, DONE=4 (3-bit).

Decomposition:
- Package sipo_pkg:
  - state enum/localparams (IDLE, SETTLE, LOG, DRAIN, DONE);
  - clog2 function for CNT_W and bit-index width.
- Sub-module sipo_shift_channel (DATA_WIDTH-bit shift register with load-on-complete output). Instantiated NUM_CH times via generate.
- FSM, bit index, settle and sample counters, and the handshake stay in the top module.

Test Plan:
All cases use DATA_WIDTH=8, NUM_CH=2, FRAME_LEN=4, SETTLE_CYCLES=2.
1. Reset: assert reset with control_signal toggling -> all outputs 0, state IDLE; release -> remains idle with no start edge.
2. Start timing: start edge at cycle t -> data_logging=1 from cycle t+3; bit_valid pulses during SETTLE do not shift.
3. Single word: ch0=0xA5, ch1=0x3C shifted MSB first over 8 strobes -> one cycle after the 8th strobe, data_ready=1, parallel_out=16'h3CA5, sample_count=1. Ack -> data_ready=0 next cycle.
4. Overrun: no ack, second word (ch0=0x11, ch1=0x22) completes -> overrun=1, parallel_out stays 16'h3CA5, sample_count=2. Repeat with ack on the completion cycle -> parallel_out=16'h2211, overrun=0.
5. Frame end: 4 words with timely acks -> DRAIN after the 4th; extra bit_valid ignored; last ack -> DONE for 1 cycle, then IDLE, sample_count=4.
6. Abort: abort after 3 bits of word 2 -> IDLE next cycle, data_ready=0, sample_count=1 held. A new start clears sample_count and overrun, and the partial bits do not appear.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO capture controller: FSM state codes and a
// width helper used to size counters from parameters.
package sipo_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_LOG    = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Ceiling log2, never less than one bit so degenerate counters stay legal.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sipo_shift_channel.sv
// One serial channel: MSB-first shift register plus an output word that is
// loaded with the just-completed value when the controller accepts it.
module sipo_shift_channel #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  shift,
  input  logic                  serial_bit,
  input  logic                  load,
  output logic [DATA_WIDTH-1:0] word
);

  logic [DATA_WIDTH-1:0] sh;

  // The output captures the shifted value including the bit arriving this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh   <= '0;
      word <= '0;
    end else begin
      if (clear) begin
        sh <= '0;
      end else if (shift) begin
        sh <= {sh[DATA_WIDTH-2:0], serial_bit};
      end
      if (load) begin
        word <= {sh[DATA_WIDTH-2:0], serial_bit};
      end
    end
  end

endmodule

// File: rtl/sipo_capture_controller.sv
// Multi-channel SIPO capture controller: start-triggered fixed-length frames,
// per-word ready/ack handshake toward logging, sticky overrun detection.
module sipo_capture_controller
  import sipo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned FRAME_LEN     = 256,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = clog2(FRAME_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         control_signal,
  input  logic                         abort,
  input  logic                         bit_valid,
  input  logic [NUM_CH-1:0]            serial_in,
  input  logic                         data_ack,
  output logic                         data_logging,
  output logic                         data_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] parallel_out,
  output logic [CNT_W-1:0]             sample_count,
  output logic                         overrun
);

  localparam int unsigned IDX_W = clog2(DATA_WIDTH);
  localparam int unsigned SET_W = clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [SET_W-1:0] SET_LAST =
    SET_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);

  logic [2:0]       state, state_nx;
  logic             ctrl_q;
  logic [IDX_W-1:0] bit_idx;
  logic [SET_W-1:0] settle_cnt;
  logic             start_edge, abort_act, shifting, complete, accept, clear_sh, overrun_evt;

  // Event decode; abort suppresses any shift or completion in the same cycle.
  always_comb begin
    start_edge  = control_signal && !ctrl_q && (state == ST_IDLE);
    abort_act   = abort && ((state == ST_SETTLE) || (state == ST_LOG) || (state == ST_DRAIN));
    shifting    = (state == ST_LOG) && bit_valid && !abort;
    complete    = shifting && (bit_idx == IDX_LAST);
    accept      = complete && (!data_ready || data_ack);
    overrun_evt = complete && data_ready && !data_ack;
    clear_sh    = start_edge || abort_act;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start_edge) state_nx = (SETTLE_CYCLES == 0) ? ST_LOG : ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SET_LAST) state_nx = ST_LOG;
      ST_LOG:    if (complete && (sample_count == CNT_LAST)) state_nx = ST_DRAIN;
      ST_DRAIN:  if (!data_ready) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
    if (abort_act) state_nx = ST_IDLE;
  end

  // Counters, handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q       <= 1'b0;
      bit_idx      <= '0;
      settle_cnt   <= '0;
      sample_count <= '0;
      data_ready   <= 1'b0;
      overrun      <= 1'b0;
      data_logging <= 1'b0;
    end else begin
      ctrl_q       <= control_signal;
      data_logging <= (state_nx == ST_LOG);
      settle_cnt   <= (state == ST_SETTLE) ? settle_cnt + SET_W'(1) : '0;

      if (clear_sh)      bit_idx <= '0;
      else if (shifting) bit_idx <= (bit_idx == IDX_LAST) ? '0 : bit_idx + IDX_W'(1);

      if (start_edge)                                 sample_count <= '0;
      else if (complete && (sample_count != CNT_FULL)) sample_count <= sample_count + CNT_W'(1);

      if (start_edge)       overrun <= 1'b0;
      else if (overrun_evt) overrun <= 1'b1;

      if (abort_act)     data_ready <= 1'b0;
      else if (accept)   data_ready <= 1'b1;
      else if (data_ack) data_ready <= 1'b0;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sipo_shift_channel #(.DATA_WIDTH(DATA_WIDTH)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear_sh),
      .shift      (shifting),
      .serial_bit (serial_in[c]),
      .load       (accept),
      .word       (parallel_out[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_sipo_capture_controller.sv
// Self-checking bench for sipo_capture_controller (8-bit words, 2 channels,
// 4-word frames, 2 settle cycles) using a queue of expected output snapshots.
`timescale 1ns/1ps
module tb_sipo_capture_controller;

  localparam int unsigned DW  = 8;
  localparam int unsigned NCH = 2;
  localparam int unsigned FL  = 4;
  localparam int unsigned SC  = 2;
  localparam int unsigned CW  = 3;

  logic clk, reset, control_signal, abort, bit_valid, data_ack;
  logic [NCH-1:0]    serial_in;
  logic              data_logging, data_ready, overrun;
  logic [NCH*DW-1:0] parallel_out;
  logic [CW-1:0]     sample_count;

  // Snapshot: parallel_out, sample_count, data_ready, overrun, data_logging
  typedef struct packed {
    logic [15:0] po;
    logic [2:0]  cnt;
    logic        rdy;
    logic        ovr;
    logic        lg;
  } obs_t;

  obs_t sb[$];
  obs_t got, exp;
  int   checks, fails;

  sipo_capture_controller #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .FRAME_LEN(FL), .SETTLE_CYCLES(SC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .control_signal (control_signal),
    .abort          (abort),
    .bit_valid      (bit_valid),
    .serial_in      (serial_in),
    .data_ack       (data_ack),
    .data_logging   (data_logging),
    .data_ready     (data_ready),
    .parallel_out   (parallel_out),
    .sample_count   (sample_count),
    .overrun        (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic obs_t snap();
    return {parallel_out, sample_count, data_ready, overrun, data_logging};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] w0, input logic [7:0] w1, input int i, input logic ack);
    bit_valid = 1'b1;
    serial_in = {w1[7-i], w0[7-i]};
    data_ack  = ack;
    step();
    bit_valid = 1'b0;
    data_ack  = 1'b0;
    serial_in = '0;
  endtask

  task automatic shift_word(input logic [7:0] w0, input logic [7:0] w1, input logic ack_last);
    for (int i = 0; i < 8; i++) strobe(w0, w1, i, (i == 7) ? ack_last : 1'b0);
  endtask

  task automatic start_frame();
    control_signal = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    control_signal = 1'b1;
    repeat (3) step();
    control_signal = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; control_signal = 1'b0; abort = 1'b0;
    bit_valid = 1'b0; data_ack = 1'b0; serial_in = '0;
    for (int i = 0; i < 3; i++) begin
      control_signal = ~control_signal;
      step();
      got = snap();
      checks++;
      if (got !== obs_t'(0) || dut.state !== 3'd0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: got %h state %0d, expected 0 state 0", i, got, dut.state);
      end
    end
    control_signal = 1'b0;
    reset = 1'b0;
    repeat (3) step();
    got = snap();
    checks++;
    if (got !== obs_t'(0) || dut.state !== 3'd0) begin
      fails++;
      $display("FAIL reset_release: got %h state %0d, expected 0 state 0", got, dut.state);
    end
  endtask

  task automatic test_start_timing();
    control_signal = 1'b1;
    step();
    checks++;
    if (data_logging !== 1'b0 || dut.state !== 3'd1) begin
      fails++;
      $display("FAIL start_t1: logging %b state %0d, expected 0 state 1", data_logging, dut.state);
    end
    bit_valid = 1'b1;
    serial_in = '1;
    step();
    checks++;
    if (data_logging !== 1'b0) begin
      fails++;
      $display("FAIL start_t2: logging %b, expected 0", data_logging);
    end
    step();
    bit_valid = 1'b0;
    serial_in = '0;
    control_signal = 1'b0;
    got = snap();
    exp = {16'h0000, 3'd0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL start_t3: got %h, expected %h", got, exp);
    end
    checks++;
    if (dut.bit_idx !== '0) begin
      fails++;
      $display("FAIL settle_no_shift: bit index %0d, expected 0", dut.bit_idx);
    end
  endtask

  task automatic test_single_word();
    sb.push_back({16'h3CA5, 3'd1, 1'b1, 1'b0, 1'b1});
    shift_word(8'hA5, 8'h3C, 1'b0);
    got = snap(); exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL single_word: got %h, expected %h", got, exp);
    end
    sb.push_back({16'h3CA5, 3'd1, 1'b0, 1'b0, 1'b1});
    data_ack = 1'b1;
    step();
    data_ack = 1'b0;
    got = snap(); exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL single_ack: got %h, expected %h", got, exp);
    end
  endtask

  task automatic test_overrun();
    for (int pass = 0; pass < 2; pass++) begin
      start_frame();
      got = snap();
      exp = {(pass == 0) ? 16'h3CA5 : 16'h3CA5, 3'd0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL ovr_start[%0d]: got %h, expected %h", pass, got, exp);
      end
      sb.push_back({16'h3CA5, 3'd1, 1'b1, 1'b0, 1'b1});
      shift_word(8'hA5, 8'h3C, 1'b0);
      got = snap(); exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL ovr_word1[%0d]: got %h, expected %h", pass, got, exp);
      end
      if (pass == 0) sb.push_back({16'h3CA5, 3'd2, 1'b1, 1'b1, 1'b1});
      else           sb.push_back({16'h2211, 3'd2, 1'b1, 1'b0, 1'b1});
      shift_word(8'h11, 8'h22, (pass == 1));
      got = snap(); exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL ovr_word2[%0d]: got %h, expected %h", pass, got, exp);
      end
    end
  endtask

  task automatic test_frame_end();
    logic [7:0] t0 [4];
    logic [7:0] t1 [4];
    t0 = '{8'h01, 8'h02, 8'h03, 8'h04};
    t1 = '{8'hF0, 8'hE0, 8'hD0, 8'hC0};
    start_frame();
    for (int k = 0; k < 4; k++) begin
      sb.push_back({t1[k], t0[k], 3'(k + 1), 1'b1, 1'b0, (k < 3)});
      shift_word(t0[k], t1[k], 1'b0);
      got = snap(); exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL frame_word[%0d]: got %h, expected %h", k, got, exp);
      end
      if (k < 3) begin
        data_ack = 1'b1;
        step();
        data_ack = 1'b0;
      end
    end
    checks++;
    if (dut.state !== 3'd3) begin
      fails++;
      $display("FAIL frame_drain: state %0d, expected 3", dut.state);
    end
    shift_word(8'hFF, 8'hFF, 1'b0);
    got = snap();
    exp = {16'hC004, 3'd4, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp || dut.state !== 3'd3) begin
      fails++;
      $display("FAIL drain_ignore: got %h state %0d, expected %h state 3", got, dut.state, exp);
    end
    data_ack = 1'b1;
    step();
    data_ack = 1'b0;
    checks++;
    if (data_ready !== 1'b0) begin
      fails++;
      $display("FAIL drain_ack: data_ready %b, expected 0", data_ready);
    end
    step();
    checks++;
    if (dut.state !== 3'd4) begin
      fails++;
      $display("FAIL frame_done: state %0d, expected 4", dut.state);
    end
    step();
    got = snap();
    exp = {16'hC004, 3'd4, 1'b0, 1'b0, 1'b0};
    checks++;
    if (got !== exp || dut.state !== 3'd0) begin
      fails++;
      $display("FAIL frame_idle: got %h state %0d, expected %h state 0", got, dut.state, exp);
    end
  endtask

  task automatic test_abort();
    start_frame();
    sb.push_back({16'hC35A, 3'd1, 1'b1, 1'b0, 1'b1});
    shift_word(8'h5A, 8'hC3, 1'b0);
    got = snap(); exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL abort_word1: got %h, expected %h", got, exp);
    end
    for (int i = 0; i < 3; i++) strobe(8'hFF, 8'hFF, i, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    got = snap();
    exp = {16'hC35A, 3'd1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (got !== exp || dut.state !== 3'd0) begin
      fails++;
      $display("FAIL abort_idle: got %h state %0d, expected %h state 0", got, dut.state, exp);
    end
    control_signal = 1'b1;
    repeat (3) step();
    control_signal = 1'b0;
    got = snap();
    exp = {16'hC35A, 3'd0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL abort_restart: got %h, expected %h", got, exp);
    end
    sb.push_back({16'h3CA5, 3'd1, 1'b1, 1'b0, 1'b1});
    shift_word(8'hA5, 8'h3C, 1'b0);
    got = snap(); exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL abort_clean_word: got %h, expected %h", got, exp);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_start_timing();
    test_single_word();
    test_overrun();
    test_frame_end();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
